// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture: tracks READ commands through a CAS-latency delay line, samples each
// burst from DQ and buffers it in a first-word-fall-through FIFO. Optional: RD_CAPTURE_LAST_EN.
module sdram_rd_capture #(
  parameter int unsigned CasLat   = 3,
  parameter int unsigned BurstLen = 4,
  parameter int unsigned DataW    = 16,
  parameter int unsigned FifoAw   = 4
) (
  input  logic              sclk_i,
  input  logic              reset_i,
  input  logic [3:0]        rd_cmd_i,
  input  logic [DataW-1:0]  sdram_dq_i,
  input  logic              flush_i,
  output logic [DataW-1:0]  rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [FifoAw:0]   fifo_level_o,
  output logic              burst_done_o,
`ifdef RD_CAPTURE_LAST_EN
  output logic              rd_last_o,
`endif
  output logic              overflow_o
);

  localparam int unsigned CntW  = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam int unsigned Depth = 2 ** FifoAw;
`ifdef RD_CAPTURE_LAST_EN
  localparam int unsigned EntryW = DataW + 1;
`else
  localparam int unsigned EntryW = DataW;
`endif
  localparam logic [3:0] CmdRead = 4'b0101;

  logic [CasLat-1:0] dly_q, dly_d;
  logic              active_q, active_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [FifoAw:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              burst_done_q, burst_done_d;
  logic              overflow_q, overflow_d;
  logic [EntryW-1:0] mem_q [Depth];

  logic              start, capture, last_beat;
  logic [CntW-1:0]   beat_idx;
  logic [FifoAw:0]   level;
  logic              empty, full, pop, push_ok;
  logic [EntryW-1:0] entry, head;

  // A new READ's first beat wins over any burst still running (burst interrupt).
  assign start     = dly_q[CasLat-1];
  assign capture   = start | active_q;
  assign beat_idx  = start ? '0 : cnt_q;
  assign last_beat = capture && (beat_idx == CntW'(BurstLen - 1));

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FifoAw] != rd_ptr_q[FifoAw]) &&
                   (wr_ptr_q[FifoAw-1:0] == rd_ptr_q[FifoAw-1:0]);
  assign pop     = !empty && rd_ready_i;
  assign push_ok = capture && (!full || pop);

`ifdef RD_CAPTURE_LAST_EN
  assign entry     = {last_beat, sdram_dq_i};
  assign rd_last_o = empty ? 1'b0 : head[DataW];
`else
  assign entry = sdram_dq_i;
`endif

  assign head         = mem_q[rd_ptr_q[FifoAw-1:0]];
  assign rd_data_o    = empty ? '0 : head[DataW-1:0];
  assign rd_valid_o   = !empty;
  assign fifo_level_o = level;
  assign burst_done_o = burst_done_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    dly_d        = '0;
    active_d     = active_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    burst_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (flush_i) begin
      active_d   = 1'b0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      dly_d[0] = (rd_cmd_i == CmdRead);
      for (int i = 1; i < CasLat; i++) begin
        dly_d[i] = dly_q[i-1];
      end
      active_d = capture && !last_beat;
      if (capture) begin
        cnt_d = beat_idx + CntW'(1);
      end
      burst_done_d = last_beat;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (capture) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_i or posedge reset_i) begin
    if (reset_i) begin
      dly_q        <= '0;
      active_q     <= 1'b0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      dly_q        <= dly_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge sclk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q[FifoAw-1:0]] <= entry;
    end
  end

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Randomized bench for sdram_rd_capture against a read-time-list / queue reference model.
// Honours RD_CAPTURE_LAST_EN when defined.
module tb_sdram_rd_capture;

  localparam int CL    = 3;
  localparam int BL    = 4;
  localparam int DEPTH = 16;
  localparam logic [3:0] READ = 4'b0101;
  localparam logic [3:0] NOP  = 4'b0111;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  rd_cmd_i;
  logic [15:0] sdram_dq_i;
  logic        flush_i;
  logic [15:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [4:0]  fifo_level_o;
  logic        burst_done_o;
  logic        overflow_o;
`ifdef RD_CAPTURE_LAST_EN
  logic        rd_last_o;
`endif

  sdram_rd_capture dut (
    .sclk_i       (clk),
    .reset_i      (reset_i),
    .rd_cmd_i     (rd_cmd_i),
    .sdram_dq_i   (sdram_dq_i),
    .flush_i      (flush_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .fifo_level_o (fifo_level_o),
    .burst_done_o (burst_done_o),
`ifdef RD_CAPTURE_LAST_EN
    .rd_last_o    (rd_last_o),
`endif
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edges at which READs were seen, plus the stored words {last, data}.
  int          reads[$];
  logic [16:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_bd  = 1'b0;
  int          cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int best;
    int idx;
    bit cap;
    if (reset_i || flush_i) begin
      reads.delete();
      mq.delete();
      m_ovf = 1'b0;
      m_bd  = 1'b0;
    end else begin
      best = -1;
      cap  = 1'b0;
      idx  = 0;
      foreach (reads[i]) if (reads[i] + CL <= cyc) best = reads[i];
      if (best >= 0 && cyc - best - CL < BL) begin
        cap = 1'b1;
        idx = cyc - best - CL;
      end
      if (mq.size() != 0 && rd_ready_i) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back({idx == BL - 1, sdram_dq_i});
        else m_ovf = 1'b1;
      end
      m_bd = cap && (idx == BL - 1);
      if (rd_cmd_i == READ) reads.push_back(cyc);
      while (reads.size() > 1 && reads[0] + CL + BL <= cyc) void'(reads.pop_front());
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("rd_valid", {31'd0, rd_valid_o}, {31'd0, mq.size() != 0});
    check("rd_data", {16'd0, rd_data_o}, (mq.size() != 0) ? {16'd0, mq[0][15:0]} : 32'd0);
    check("fifo_level", {27'd0, fifo_level_o}, mq.size());
    check("burst_done", {31'd0, burst_done_o}, {31'd0, m_bd});
    check("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
`ifdef RD_CAPTURE_LAST_EN
    check("rd_last", {31'd0, rd_last_o}, (mq.size() != 0) ? {31'd0, mq[0][16]} : 32'd0);
`endif
  endtask

  // Inputs are stable here; advance model, clock the DUT, compare on the falling edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rd_cmd_i   = NOP;
      sdram_dq_i = 16'($urandom);
      tick();
    end
  endtask

  task automatic cmd(input logic [3:0] c);
    rd_cmd_i   = c;
    sdram_dq_i = 16'($urandom);
    tick();
  endtask

  int pulses;

  initial begin
    reset_i    = 1'b1;
    rd_cmd_i   = NOP;
    sdram_dq_i = '0;
    flush_i    = 1'b0;
    rd_ready_i = 1'b0;
    tick();
    check("reset_level", {27'd0, fifo_level_o}, 32'd0);
    check("reset_valid", {31'd0, rd_valid_o}, 32'd0);
    reset_i = 1'b0;
    idle(2);

    // Single burst with known data.
    cmd(READ);
    idle(2);
    sdram_dq_i = 16'h1111; rd_cmd_i = NOP; tick();
    check("t1_valid_after_first", {31'd0, rd_valid_o}, 32'd1);
    check("t1_head", {16'd0, rd_data_o}, 32'h1111);
    sdram_dq_i = 16'h2222; tick();
    sdram_dq_i = 16'h3333; tick();
    sdram_dq_i = 16'h4444; tick();
    check("t1_burst_done", {31'd0, burst_done_o}, 32'd1);
    check("t1_level", {27'd0, fifo_level_o}, 32'd4);
    idle(1);
    check("t1_done_pulse_ends", {31'd0, burst_done_o}, 32'd0);

    // Five back-to-back bursts into a stalled FIFO.
    flush_i = 1'b1; idle(1); flush_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      cmd(READ);
      idle(3);
    end
    idle(6);
    check("t3_level_full", {27'd0, fifo_level_o}, 32'd16);
    check("t3_overflow", {31'd0, overflow_o}, 32'd1);
    rd_ready_i = 1'b1;
    idle(20);
    check("t3_drained", {27'd0, fifo_level_o}, 32'd0);
    rd_ready_i = 1'b0;

    // Interrupted burst.
    flush_i = 1'b1; idle(1); flush_i = 1'b0;
    cmd(READ);
    idle(1);
    cmd(READ);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (burst_done_o) pulses++;
    end
    check("t4_level", {27'd0, fifo_level_o}, 32'd6);
    check("t4_pulses", pulses, 32'd1);

    // Flush mid-burst with 8 words stored.
    flush_i = 1'b1; idle(1); flush_i = 1'b0;
    cmd(READ); idle(3); cmd(READ); idle(8);
    check("t5_level_pre", {27'd0, fifo_level_o}, 32'd8);
    cmd(READ); idle(3);
    flush_i = 1'b1; idle(1); flush_i = 1'b0;
    check("t5_level", {27'd0, fifo_level_o}, 32'd0);
    check("t5_valid", {31'd0, rd_valid_o}, 32'd0);
    idle(6);
    check("t5_ignored", {27'd0, fifo_level_o}, 32'd0);

    // Reset mid-burst.
    cmd(READ); idle(4);
    reset_i = 1'b1; idle(1); reset_i = 1'b0;
    check("t6_level", {27'd0, fifo_level_o}, 32'd0);
    idle(4);
    cmd(READ); idle(8);
    check("t6_level_after", {27'd0, fifo_level_o}, 32'd4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rd_cmd_i   = ($urandom_range(3) == 0) ? READ : 4'($urandom_range(15));
      if (rd_cmd_i == READ && i[0]) rd_cmd_i = NOP;
      sdram_dq_i = 16'($urandom);
      rd_ready_i = ($urandom_range(2) != 0);
      flush_i    = ($urandom_range(99) == 0);
      reset_i    = ($urandom_range(249) == 0);
      tick();
    end
    reset_i = 1'b0;
    flush_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
